// File: rtl/cpu4_uart_tx.sv
// Memory-mapped UART transmitter for the cpu4 core: a 4-entry byte FIFO written through
// TXDATA, a STATUS register read with one-cycle latency, and an 8N1 serializer.
module cpu4_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        tx_busy
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [29:0] TxWord  = BASE_ADDR[31:2];
  localparam logic [29:0] StWord  = TxWord + 30'd1;
  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  // Byte lanes and word-offset bits that the register map never looks at.
  logic unused_bits;
  assign unused_bits = ^{dataadr[1:0], writedata[31:8]};

  logic sel_tx, sel_st, st_addr;
  assign st_addr = (dataadr[31:2] == StWord);
  assign sel_tx  = memwrite & (dataadr[31:2] == TxWord);
  assign sel_st  = memwrite & st_addr;

  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       full, empty, push, pop;
  logic [7:0] head;

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign head  = fifo_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a store to a full FIFO still lands.
  assign push  = sel_tx & (~full | pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (sel_tx && full && !pop) begin
      ovf_d = 1'b1;
    end else if (sel_st) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        cnt_last;

  assign cnt_last = (bit_cnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head;
          state_d   = StStart;
          bit_cnt_d = 16'd0;
          txd_d     = 1'b0;
        end
      end
      StStart: begin
        if (cnt_last) begin
          bit_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = StData;
          txd_d     = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_last) begin
          bit_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          bit_cnt_d = 16'd0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
            txd_d   = 1'b0;
          end else begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  logic [31:0] status, readdata_q, readdata_d;

  assign status     = {25'd0, count_q, empty, ovf_q, full, (state_q != StIdle)};
  assign readdata_d = st_addr ? status : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != StIdle);

endmodule
